frog_mover: RTL and testbench

- Parametrised next-generation player movement controller for the frogger game.
- Takes debounced d-pad levels and produces grid-stepped hops, with optional hold-to-repeat.
- Applies platform carry (log/turtle drift), detects push-off at screen edges, and flags goal-row arrival.
- Sits between the input debouncers and the game FSM / renderer; outputs feed collision and sprite draw logic.

---
 rtl/frog_mover.sv | 185 ++++++++++++++++++
 tb/tb_frog_mover.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/frog_mover.sv
// Frogger player movement: edge-triggered grid hops, platform carry with edge push-off, goal-row flag.
// Define FROG_HOP_REPEAT_EN to add hold-to-repeat hops; without it only rising edges hop.
module frog_mover #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BLOCK        = 32,
  parameter int END_Y        = 15,
  parameter int COORD_W      = 10,
  parameter int VEL_W        = 4,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 8333333
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         state,
  input  logic [COORD_W-1:0] init_x,
  input  logic [COORD_W-1:0] init_y,
  input  logic [COORD_W-1:0] frog_size,
  input  logic [3:0]         dpad_level,
  input  logic               collision,
  input  logic               carry_en,
  input  logic [VEL_W-1:0]   carry_vel,
  input  logic               carry_tick,
  output logic [COORD_W-1:0] next_x,
  output logic [COORD_W-1:0] next_y,
  output logic               reached_end,
  output logic               pushed_off,
  output logic               hop_pulse
);

  localparam logic [1:0] ST_PLAYING = 2'd1;
  localparam int SW = COORD_W + 2;
  localparam int UW = SW + 1;
  localparam logic [SW-1:0] BLK_U = SW'(BLOCK);
  localparam logic signed [SW-1:0] BLK_S = SW'(BLOCK);

  // Repeat reload is REPEAT_DELAY-REPEAT_RATE, so the rate may not exceed the delay.
  if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
    $error("frog_mover: REPEAT_RATE must be in 1..REPEAT_DELAY");
  end

  logic [3:0] prev_level;
  logic       respawn_pend;
  logic       playing;
  logic       respawn;
  logic [3:0] rise;
  logic [3:0] rpt_req;
  logic [3:0] req;

  assign playing = (state == ST_PLAYING);
  assign respawn = respawn_pend | collision;
  assign rise    = dpad_level & ~prev_level;
  assign req     = rise | rpt_req;

`ifdef FROG_HOP_REPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [CNT_W-1:0] rpt_cnt;
  logic             single_held;
  logic             same_held;
  logic             rpt_fire;

  assign single_held = (dpad_level != 4'd0) && ((dpad_level & (dpad_level - 4'd1)) == 4'd0);
  assign same_held   = (dpad_level == prev_level);
  assign rpt_fire    = playing && single_held && same_held && (rpt_cnt == CNT_LAST);
  assign rpt_req     = rpt_fire ? dpad_level : 4'd0;

  // Counter restarts whenever the held pattern is not one stable direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt <= '0;
    end else if (respawn || !playing || !single_held || !same_held) begin
      rpt_cnt <= '0;
    end else if (rpt_cnt == CNT_LAST) begin
      rpt_cnt <= CNT_RELOAD;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  assign rpt_req = 4'd0;
`endif

  logic                  go_up, go_down, go_left, go_right;
  logic                  up_ok, down_ok, left_ok, right_ok;
  logic [SW-1:0]         xs, ys, fs;
  logic                  hop_ok;
  logic [COORD_W-1:0]    hop_x, hop_y;
  logic signed [SW-1:0]  hop_dx;
  logic signed [SW-1:0]  vel_s;
  logic signed [SW-1:0]  x_new;
  logic [UW-1:0]         edge_sum;
  logic                  carry_now;
  logic                  under, over;
  logic [COORD_W-1:0]    x_carry;

  assign xs = {2'b00, next_x};
  assign ys = {2'b00, next_y};
  assign fs = {2'b00, frog_size};

  // Priority up > down > left > right; a blocked winner does not fall through.
  assign go_up    = req[2];
  assign go_down  = !req[2] && req[1];
  assign go_left  = !req[2] && !req[1] && req[0];
  assign go_right = (req[2:0] == 3'd0) && req[3];

  assign up_ok    = ys >= BLK_U;
  assign down_ok  = (ys + BLK_U + fs) <= SW'(SCREEN_H);
  assign left_ok  = xs >= BLK_U;
  assign right_ok = (xs + BLK_U + fs) <= SW'(SCREEN_W);

  always_comb begin
    hop_ok = 1'b0;
    hop_x  = next_x;
    hop_y  = next_y;
    hop_dx = '0;
    if (go_up && up_ok) begin
      hop_ok = 1'b1;
      hop_y  = next_y - COORD_W'(BLOCK);
    end else if (go_down && down_ok) begin
      hop_ok = 1'b1;
      hop_y  = next_y + COORD_W'(BLOCK);
    end else if (go_left && left_ok) begin
      hop_ok = 1'b1;
      hop_x  = next_x - COORD_W'(BLOCK);
      hop_dx = -BLK_S;
    end else if (go_right && right_ok) begin
      hop_ok = 1'b1;
      hop_x  = next_x + COORD_W'(BLOCK);
      hop_dx = BLK_S;
    end
  end

  assign carry_now = playing && carry_en && carry_tick;
  assign vel_s     = {{(SW-VEL_W){carry_vel[VEL_W-1]}}, carry_vel};
  assign x_new     = $signed(xs) + vel_s + hop_dx;
  assign edge_sum  = {1'b0, x_new} + UW'(frog_size);
  assign under     = x_new[SW-1];
  assign over      = !under && (edge_sum > UW'(SCREEN_W));

  always_comb begin
    x_carry = x_new[COORD_W-1:0];
    if (under) begin
      x_carry = '0;
    end else if (over) begin
      x_carry = COORD_W'(SCREEN_W) - frog_size;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_x       <= '0;
      next_y       <= '0;
      reached_end  <= 1'b0;
      pushed_off   <= 1'b0;
      hop_pulse    <= 1'b0;
      prev_level   <= 4'd0;
      respawn_pend <= 1'b1;
    end else begin
      prev_level <= dpad_level;
      pushed_off <= 1'b0;
      hop_pulse  <= 1'b0;
      if (respawn) begin
        next_x       <= init_x;
        next_y       <= init_y;
        reached_end  <= 1'b0;
        respawn_pend <= 1'b0;
      end else if (playing) begin
        reached_end <= (next_y <= COORD_W'(END_Y));
        hop_pulse   <= hop_ok;
        next_y      <= hop_y;
        if (carry_now) begin
          next_x     <= x_carry;
          pushed_off <= under || over;
        end else begin
          next_x <= hop_x;
        end
      end
    end
  end

endmodule

// File: tb/tb_frog_mover.sv
// Directed bench for frog_mover with short repeat timing (delay 10, rate 4).
// Expectations follow FROG_HOP_REPEAT_EN the same way the design does.
module tb_frog_mover;

`ifdef FROG_HOP_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [1:0] state;
  logic [9:0] init_x, init_y, frog_size;
  logic [3:0] dpad_level;
  logic       collision, carry_en, carry_tick;
  logic [3:0] carry_vel;
  logic [9:0] next_x, next_y;
  logic       reached_end, pushed_off, hop_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int ex, ey;
  bit eh;

  frog_mover #(
    .REPEAT_DELAY(10),
    .REPEAT_RATE (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .state      (state),
    .init_x     (init_x),
    .init_y     (init_y),
    .frog_size  (frog_size),
    .dpad_level (dpad_level),
    .collision  (collision),
    .carry_en   (carry_en),
    .carry_vel  (carry_vel),
    .carry_tick (carry_tick),
    .next_x     (next_x),
    .next_y     (next_y),
    .reached_end(reached_end),
    .pushed_off (pushed_off),
    .hop_pulse  (hop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic respawn_at(input int x, input int y);
    init_x    = 10'(x);
    init_y    = 10'(y);
    collision = 1'b1;
    tick();
    collision = 1'b0;
  endtask

  initial begin
    reset = 1'b1; state = 2'd0; init_x = 10'd304; init_y = 10'd448; frog_size = 10'd32;
    dpad_level = 4'd0; collision = 1'b0; carry_en = 1'b0; carry_vel = 4'd0; carry_tick = 1'b0;
    tick(); tick();
    chk("rst_x", 32'(next_x), 0);
    chk("rst_y", 32'(next_y), 0);
    chk("rst_hop", 32'(hop_pulse), 0);
    chk("rst_push", 32'(pushed_off), 0);
    chk("rst_end", 32'(reached_end), 0);

    reset = 1'b0;
    tick();
    chk("spawn_x", 32'(next_x), 304);
    chk("spawn_y", 32'(next_y), 448);
    chk("spawn_hop", 32'(hop_pulse), 0);
    chk("spawn_push", 32'(pushed_off), 0);
    chk("spawn_end", 32'(reached_end), 0);

    // Fourteen up hops take y from 448 to 0.
    state = 2'd1;
    ey = 448;
    for (int k = 1; k <= 14; k++) begin
      dpad_level = 4'b0100;
      tick();
      ey -= 32;
      chk("up_y", 32'(next_y), 32'(ey));
      chk("up_hop", 32'(hop_pulse), 1);
      chk("up_end", 32'(reached_end), 0);
      dpad_level = 4'd0;
      tick();
      chk("up_hop_clr", 32'(hop_pulse), 0);
      chk("up_end_lag", 32'(reached_end), (ey <= 15) ? 1 : 0);
    end
    dpad_level = 4'b0100;
    tick();
    chk("up_block_y", 32'(next_y), 0);
    chk("up_block_hop", 32'(hop_pulse), 0);
    dpad_level = 4'd0;
    tick();
    chk("goal_end", 32'(reached_end), 1);

    respawn_at(608, 224);
    chk("coll_x", 32'(next_x), 608);
    chk("coll_y", 32'(next_y), 224);
    chk("coll_end", 32'(reached_end), 0);
    dpad_level = 4'b1000;
    tick();
    chk("right_block_x", 32'(next_x), 608);
    chk("right_block_hop", 32'(hop_pulse), 0);
    dpad_level = 4'd0;
    tick();
    dpad_level = 4'b0001;
    tick();
    chk("left_x", 32'(next_x), 576);
    chk("left_hop", 32'(hop_pulse), 1);
    dpad_level = 4'd0;
    tick();
    chk("left_hop_clr", 32'(hop_pulse), 0);
    chk("left_x_hold", 32'(next_x), 576);

    // Up and down together: only up, and no repeat while two bits are held.
    dpad_level = 4'b0110;
    tick();
    chk("updown_y", 32'(next_y), 192);
    chk("updown_hop", 32'(hop_pulse), 1);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("updown_hold_y", 32'(next_y), 192);
    end
    dpad_level = 4'd0;
    tick();

    // Hold left for 30 cycles.
    ex = 576;
    dpad_level = 4'b0001;
    for (int i = 1; i <= 30; i++) begin
      tick();
      eh = (i == 1) || (REP && i >= 11 && ((i - 11) % 4) == 0);
      if (eh) ex -= 32;
      chk("hold_x", 32'(next_x), 32'(ex));
      chk("hold_hop", 32'(hop_pulse), 32'(eh));
    end
    dpad_level = 4'd0;
    tick();

    respawn_at(1, 224);
    carry_en = 1'b1; carry_vel = 4'hD; carry_tick = 1'b1;
    tick();
    chk("carry_left_x", 32'(next_x), 0);
    chk("carry_left_push", 32'(pushed_off), 1);
    carry_tick = 1'b0;
    tick();
    chk("carry_left_push_clr", 32'(pushed_off), 0);
    chk("carry_left_x_hold", 32'(next_x), 0);

    respawn_at(604, 224);
    carry_vel = 4'd5; carry_tick = 1'b1;
    tick();
    chk("carry_right_x", 32'(next_x), 608);
    chk("carry_right_push", 32'(pushed_off), 1);
    carry_tick = 1'b0;
    tick();
    chk("carry_right_push_clr", 32'(pushed_off), 0);

    respawn_at(100, 224);
    carry_tick = 1'b1;
    tick();
    chk("carry_mid_x", 32'(next_x), 105);
    chk("carry_mid_push", 32'(pushed_off), 0);
    dpad_level = 4'b0001;
    tick();
    chk("carry_hop_x", 32'(next_x), 78);
    chk("carry_hop_hop", 32'(hop_pulse), 1);
    chk("carry_hop_push", 32'(pushed_off), 0);
    dpad_level = 4'd0; carry_tick = 1'b0;
    tick();

    state = 2'd2;
    dpad_level = 4'b0100; carry_tick = 1'b1;
    tick();
    chk("dead_x", 32'(next_x), 78);
    chk("dead_y", 32'(next_y), 224);
    chk("dead_hop", 32'(hop_pulse), 0);
    chk("dead_push", 32'(pushed_off), 0);
    dpad_level = 4'd0; carry_tick = 1'b0;
    tick();
    state = 2'd1;

    respawn_at(304, 0);
    chk("goal2_end_clr", 32'(reached_end), 0);
    tick();
    chk("goal2_end", 32'(reached_end), 1);

    // Collision beats a simultaneous right edge and carry tick.
    init_y = 10'd448; collision = 1'b1; dpad_level = 4'b1000; carry_tick = 1'b1;
    tick();
    chk("coll_all_x", 32'(next_x), 304);
    chk("coll_all_y", 32'(next_y), 448);
    chk("coll_all_hop", 32'(hop_pulse), 0);
    chk("coll_all_push", 32'(pushed_off), 0);
    chk("coll_all_end", 32'(reached_end), 0);
    collision = 1'b0; dpad_level = 4'd0; carry_tick = 1'b0; carry_en = 1'b0;
    tick();

    dpad_level = 4'b0001;
    tick();
    chk("pre_areset_x", 32'(next_x), 272);
    chk("pre_areset_hop", 32'(hop_pulse), 1);
    #2 reset = 1'b1;
    #1;
    chk("areset_x", 32'(next_x), 0);
    chk("areset_y", 32'(next_y), 0);
    chk("areset_hop", 32'(hop_pulse), 0);
    chk("areset_end", 32'(reached_end), 0);
    dpad_level = 4'd0;
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
